// File: rtl/pea_firing_scheduler.sv
// Firing-cycle sequencer for the PEA actor: walks the CFDF cycle (settle, check enable,
// invoke, wait for FC), adopts the actor-reported next mode and counts firings/stalls.
module pea_firing_scheduler #(
  parameter int         CNT_W       = 16,
  parameter int         TIMEOUT     = 1024,
  parameter logic [1:0] SETUP_INSTR = 2'b00,
  parameter logic [1:0] INSTR       = 2'b01,
  parameter logic [1:0] OUTPUT      = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] num_firings,
  input  logic             enable,
  input  logic             FC,
  input  logic [1:0]       next_mode_in,
  output logic             invoke,
  output logic [1:0]       next_instr,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] firing_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [2:0]       state_dbg
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CHECK   = 3'd2,
    INVOKE  = 3'd3,
    WAIT_FC = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer;
  logic             stop_pending;
  logic             limit_hit;
  logic             timer_last;

  // Any code the actor reports that is not a known mode falls back to setup.
  function automatic logic [1:0] legal_mode(input logic [1:0] m);
    if (m == SETUP_INSTR || m == INSTR || m == OUTPUT) return m;
    return SETUP_INSTR;
  endfunction

  assign limit_hit  = (num_firings != '0) && (firing_count == num_firings);
  assign timer_last = (timer == TMR_W'(TIMEOUT - 1));
  assign state_dbg  = state;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !timeout_err) state_n = SETTLE;
      SETTLE:  state_n = CHECK;
      CHECK: begin
        if (stop_pending || limit_hit) state_n = DONE;
        else if (enable)               state_n = INVOKE;
      end
      INVOKE:  state_n = WAIT_FC;
      WAIT_FC: begin
        if (FC)              state_n = SETTLE;
        else if (timer_last) state_n = ERROR;
      end
      DONE:    state_n = IDLE;
      ERROR:   state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      invoke       <= 1'b0;
      next_instr   <= SETUP_INSTR;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      firing_count <= '0;
      stall_count  <= '0;
      stop_pending <= 1'b0;
      timer        <= '0;
    end else begin
      state  <= state_n;
      // Pulse outputs are decoded from the next state so they line up with that state.
      invoke <= (state_n == INVOKE);
      done   <= (state_n == DONE);
      if (state_n == ERROR) timeout_err <= 1'b1;
      if (state_n == DONE || state_n == ERROR) busy <= 1'b0;

      case (state)
        IDLE: begin
          if (state_n == SETTLE) begin
            firing_count <= '0;
            stall_count  <= '0;
            next_instr   <= SETUP_INSTR;
            busy         <= 1'b1;
          end
        end
        CHECK: begin
          if (state_n == CHECK && stall_count != '1) stall_count <= stall_count + 1'b1;
        end
        INVOKE: timer <= '0;
        WAIT_FC: begin
          if (FC) begin
            next_instr <= legal_mode(next_mode_in);
            if (firing_count != '1) firing_count <= firing_count + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase

      // A stop request is remembered for the whole run and only honoured at CHECK.
      if (state == DONE || state == IDLE) stop_pending <= 1'b0;
      else if (busy && stop)              stop_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pea_firing_scheduler.sv
// Self-checking bench for pea_firing_scheduler: directed and randomized firing plans,
// expected timing derived from the firing-cycle rules (phase start + settle/check/stalls).
module tb_pea_firing_scheduler;
  localparam int         CNT_W   = 16;
  localparam int         TIMEOUT = 8;
  localparam logic [1:0] SETUP   = 2'b00;

  logic             clk, rst, start, stop, enable, fc;
  logic [CNT_W-1:0] num_firings;
  logic [1:0]       next_mode_in;
  logic             invoke, busy, done, timeout_err;
  logic [1:0]       next_instr;
  logic [CNT_W-1:0] firing_count, stall_count;
  logic [2:0]       state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-firing plan: CHECK stall cycles, FC latency after invoke, reported next mode.
  int         stall_a[8];
  int         lat_a[8];
  logic [1:0] mode_a[8];

  pea_firing_scheduler #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
    .SETUP_INSTR(2'b00), .INSTR(2'b01), .OUTPUT(2'b10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_firings(num_firings),
    .enable(enable), .FC(fc), .next_mode_in(next_mode_in), .invoke(invoke),
    .next_instr(next_instr), .busy(busy), .done(done), .timeout_err(timeout_err),
    .firing_count(firing_count), .stall_count(stall_count), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_mode(input logic [1:0] m);
    return (m == 2'b11) ? SETUP : m;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_invoke"}, invoke, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_instr"}, next_instr, SETUP);
    chk({tag, "_fcnt"}, firing_count, 0);
    chk({tag, "_scnt"}, stall_count, 0);
  endtask

  // One run. p is the cycle in which start or the last FC was driven; CHECK begins at
  // p+2, invoke lands at p+3+stalls, and a finishing run pulses done at p+3.
  task automatic do_run(input int nf, input int n_plan, input int stop_fire,
                        input int abort_fire, input int hang_fire, input bit stray);
    int p, inv_c, f, exp_stall, fired;
    bit ending;
    exp_stall = 0;
    fired     = 0;
    ending    = 0;
    num_firings = CNT_W'(nf);
    start = 1'b1;
    p = cyc;
    tick();
    start = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_instr", next_instr, SETUP);
    chk("run_fcnt", firing_count, 0);
    chk("run_scnt", stall_count, 0);

    for (int i = 0; i < n_plan && !ending; i++) begin
      inv_c = p + 3 + stall_a[i];
      while (cyc < inv_c) begin
        enable = (cyc >= p + 2) ? (cyc >= p + 2 + stall_a[i]) : 1'($urandom_range(0, 1));
        fc = stray && (cyc >= p + 2) && (cyc < p + 2 + stall_a[i]) && ($urandom_range(0, 1) == 1);
        next_mode_in = 2'($urandom_range(0, 3));
        tick();
        chk("invoke_pulse", invoke, cyc == inv_c);
      end
      fc = 1'b0;
      exp_stall += stall_a[i];
      chk("stall_acc", stall_count, exp_stall);
      chk("fcnt_stray", firing_count, fired);

      if (i == hang_fire) begin
        for (int k = 0; k < TIMEOUT + 2; k++) begin
          enable = 1'($urandom_range(0, 1));
          tick();
          chk("hang_no_invoke", invoke, 0);
          if (cyc == inv_c + TIMEOUT) begin
            chk("hang_err_early", timeout_err, 0);
            chk("hang_busy", busy, 1);
          end
        end
        chk("hang_err", timeout_err, 1);
        chk("hang_busy_low", busy, 0);
        return;
      end

      f = inv_c + lat_a[i];
      while (cyc < f) begin
        enable = 1'($urandom_range(0, 1));
        start  = 1'($urandom_range(0, 1));
        stop   = (i == stop_fire) && (cyc == inv_c + 1);
        if (i == abort_fire && cyc == inv_c + 1) begin
          start = 1'b0;
          #2 rst = 1'b1;
          #1 chk_reset_values("async_rst");
          tick();
          rst = 1'b0;
          return;
        end
        tick();
        chk("wait_no_invoke", invoke, 0);
      end
      start = 1'b0;
      stop  = 1'b0;
      if (i == stop_fire) ending = 1'b1;
      fc = 1'b1;
      next_mode_in = mode_a[i];
      tick();
      fc = 1'b0;
      fired++;
      chk("fc_instr", next_instr, exp_mode(mode_a[i]));
      chk("fc_count", firing_count, fired);
      p = f;
      if (nf != 0 && fired == nf) ending = 1'b1;
    end

    // enable stays high here: the end condition must win over a ready actor.
    while (cyc < p + 3) begin
      enable = 1'b1;
      tick();
      chk("end_no_invoke", invoke, 0);
      chk("done_pulse", done, cyc == p + 3);
    end
    chk("end_fcnt", firing_count, fired);
    chk("end_scnt", stall_count, exp_stall);
    enable = 1'b0;
    tick();
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_no_invoke", invoke, 0);
    tick();
    tick();
    chk("fcnt_hold", firing_count, fired);
    chk("instr_hold", next_instr, exp_mode(mode_a[fired - 1]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; enable = 1'b0; fc = 1'b0;
    num_firings = '0; next_mode_in = 2'b00;
    tick();
    tick();
    chk_reset_values("reset");
    rst = 1'b0;
    tick();

    // stop while idle must not leak into the next run
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("idle_stop_busy", busy, 0);

    // normal 3-mode run
    stall_a = '{0, 0, 0, 0, 0, 0, 0, 0};
    lat_a   = '{2, 2, 2, 2, 2, 2, 2, 2};
    mode_a  = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    do_run(3, 3, -1, -1, -1, 1'b0);

    // 5-cycle stall with stray FC in CHECK, then an illegal reported mode
    stall_a = '{5, 0, 0, 0, 0, 0, 0, 0};
    lat_a   = '{1, 3, 2, 2, 2, 2, 2, 2};
    mode_a  = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    do_run(2, 2, -1, -1, -1, 1'b1);

    // unlimited run stopped during the second firing's WAIT_FC, FC 3 cycles after stop
    stall_a = '{0, 1, 0, 0, 0, 0, 0, 0};
    lat_a   = '{2, 4, 2, 2, 2, 2, 2, 2};
    mode_a  = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    do_run(0, 4, 1, -1, -1, 1'b0);

    // randomized plans
    for (int r = 0; r < 6; r++) begin
      int nf;
      nf = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) begin
        stall_a[k] = $urandom_range(0, 3);
        lat_a[k]   = $urandom_range(1, TIMEOUT - 2);
        mode_a[k]  = 2'($urandom_range(0, 3));
      end
      do_run(nf, nf, -1, -1, -1, 1'b1);
    end

    // async reset during the second firing, then a fresh run
    stall_a = '{0, 0, 0, 0, 0, 0, 0, 0};
    lat_a   = '{2, 3, 2, 2, 2, 2, 2, 2};
    mode_a  = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    do_run(0, 2, -1, 1, -1, 1'b0);
    tick();
    chk_reset_values("post_rst");
    mode_a  = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    do_run(1, 1, -1, -1, -1, 1'b0);

    // hung firing, start ignored afterwards, reset clears the sticky flag
    do_run(1, 1, -1, -1, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      enable = 1'b1;
      tick();
      chk("err_no_invoke", invoke, 0);
      chk("err_busy", busy, 0);
      chk("err_sticky", timeout_err, 1);
    end
    #2 rst = 1'b1;
    #1 chk("rst_clears_terr", timeout_err, 0);
    tick();
    rst = 1'b0;
    tick();
    chk_reset_values("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pea_firing_scheduler.md
Name: pea_firing_scheduler

Overview:
- Sequences the PEA actor through its CFDF firing cycle without testbench hand-holding.
- Presents the current mode on next_instr to the enable and invoke logic, and samples enable.
- Issues a one-cycle invoke, waits for FC, then adopts the actor-reported next mode.
- Sits between the host/top level and the PEA enable/invoke pair; counts firings, stalls and hung firings.

Parameters:
CNT_W, 16, width of firing/stall counters and num_firings
TIMEOUT, 1024, max cycles in WAIT_FC before declaring a hung firing (>=2)
SETUP_INSTR, 2'b00, initial/fallback mode code
INSTR, 2'b01, instruction mode code
OUTPUT, 2'b10, output mode code

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run (pulse, sampled in IDLE only)
stop  in  1  request halt after the in-flight firing (sampled while busy)
num_firings  in  CNT_W  firings per run; 0 = unlimited
enable  in  1  combinational enable from PEA enable module for the current next_instr
FC  in  1  firing-complete pulse from PEA invoke module
next_mode_in  in  2  next mode reported by actor, valid when FC=1
invoke  out  1  one-cycle firing request to actor
next_instr  out  2  current mode driven to actor and enable module
busy  out  1  high from run start until DONE/ERROR
done  out  1  one-cycle pulse at normal run completion
timeout_err  out  1  sticky hung-firing flag
firing_count  out  CNT_W  completed firings this run, saturating
stall_count  out  CNT_W  CHECK cycles with enable low this run, saturating

Behaviour:
- Reset (async, any state, including mid-firing): state IDLE, invoke=0, next_instr=SETUP_INSTR, busy=0, done=0, timeout_err=0, both counters=0, stop_pending=0, timer=0.
- All outputs are registered.
- States: IDLE, CHECK, INVOKE, WAIT_FC, SETTLE, DONE, ERROR.
- IDLE:
  - start=1 and timeout_err=0 -> clear counters, next_instr<=SETUP_INSTR, busy<=1, goto SETTLE.
  - start is ignored when timeout_err=1.
- SETTLE: one cycle so that enable recomputes from the new next_instr -> CHECK.
- CHECK, priority order:
  1. stop_pending, or (num_firings!=0 and firing_count==num_firings) -> DONE.
  2. enable=1 -> INVOKE.
  3. Otherwise stall_count++ (saturates at all-ones) and stay in CHECK.
- INVOKE: invoke=1 for exactly this cycle; timer<=0; -> WAIT_FC.
- WAIT_FC:
  - FC=1 -> next_instr<=next_mode_in (2'b11 maps to SETUP_INSTR), firing_count++ (saturating), -> SETTLE.
  - Else timer++; timer==TIMEOUT-1 without FC -> ERROR.
  - FC and timeout in the same cycle: FC wins.
- DONE: done=1 one cycle, busy<=0, stop_pending<=0 -> IDLE. next_instr holds its last value.
- ERROR: timeout_err<=1, busy<=0, invoke=0. Remains in ERROR until rst.
- Run latency: start sampled at edge t -> SETTLE at t+1, CHECK at t+2, invoke high in cycle t+3 if enable=1.
- Minimum firing period is 4 cycles plus actor latency (INVOKE, WAIT_FC>=1, SETTLE, CHECK).
- stop:
  - Any cycle with busy=1 sets stop_pending; it takes effect at the next CHECK.
  - stop in IDLE is ignored.
  - stop never aborts WAIT_FC.
- start while busy: ignored.
- FC outside WAIT_FC: ignored; no count.
- invoke is never asserted outside INVOKE and never in consecutive cycles.
- Counters hold their values after DONE until the next start.

Test Plan:
- Normal 3-mode run: num_firings=3, enable=1; actor returns FC 2 cycles after invoke with next_mode_in 01, 10, 00 -> exactly 3 invoke pulses; next_instr 00->01->10->00; firing_count=3; one done pulse; busy low after.
- Stall: enable=0 for 5 CHECK cycles, then 1 -> stall_count=5; invoke asserted in the cycle after enable rises in CHECK.
- Timeout: TIMEOUT=8, FC never asserted -> ERROR after 8 WAIT_FC cycles; timeout_err=1, busy=0; a later start is ignored; rst clears timeout_err to 0.
- Stop mid-firing: num_firings=0, stop pulsed during WAIT_FC, FC arrives 3 cycles later -> firing completes and counts; no further invoke; done pulses from the following CHECK.
- Illegal mode and late FC: next_mode_in=11 with FC -> next_instr=00. FC pulsed while in CHECK -> firing_count unchanged.
- Async reset mid-run: assert rst during WAIT_FC, off a clock edge -> all outputs at reset values immediately; after rst drops, a start begins a fresh run from SETUP_INSTR.
